uart_byte_rx: RTL and testbench

- Asynchronous serial byte receiver, 8N1 framing, LSB first.
- Receive-side counterpart of uart_byte_tx; shares its baud_set encoding and clock.
- Sits between the board RX pin and the byte-level consumer logic.
- Uses 16x oversampling with a 3-sample majority vote per bit, and reports each completed byte with a one-cycle rx_done pulse.

---
 rtl/uart_pkg.sv | 50 +++++
 rtl/uart_rx_sync.sv | 47 ++++
 rtl/uart_byte_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_byte_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART byte transmitter and receiver.
//   - BAUD_* : baud_set codes (codes above BAUD_115200 also select 115200)
//   - OVERSAMPLE : oversample ticks per bit
//   - baud_div_term() : baud_set -> terminal count (DIV-1) of the tick divider
//   - majority3() : 2-of-3 vote used for the bit decision
//   - rx_state_e : receiver FSM state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    // The divider is wider than 50 MHz needs, so a faster CLK_FREQ still fits.
    localparam int unsigned DIV_W = 16;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    // Last tick of a frame: slot 9 (stop), phase 8.
    localparam logic [7:0] TICK_LAST = 8'd152;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } rx_state_e;

    // Truncating division gives 324/161/80/53/26 at 50 MHz.
    function automatic logic [DIV_W-1:0] baud_div_term(input logic [2:0] baud_set,
                                                       input int unsigned clk_freq);
        int unsigned rate;
        case (baud_set)
            BAUD_9600:  rate = 9600;
            BAUD_19200: rate = 19200;
            BAUD_38400: rate = 38400;
            BAUD_57600: rate = 57600;
            default:    rate = 115200;
        endcase
        return DIV_W'(clk_freq / (OVERSAMPLE * rate) - 1);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous RX pin into the clk domain and flags start bits.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset; all flops reset to idle (1)
//   rx_async   : raw serial line, idle high
//   rx_sync    : line level after the 2-FF synchronizer
//   start_det  : 1 when the synchronized line is 0 and was 1 one clock earlier
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic rx_async,
    output logic rx_sync,
    output logic start_det
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = rx_async;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Resetting to the idle level means a line held low through reset is not
    // mistaken for a start bit; it must rise and fall again first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make all three stages sample their
            // inputs before any of them update, so this is a true shift chain.
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_sync   = sync_q;
    assign start_det = prev_q & ~sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// 8N1 serial byte receiver, LSB first, 16x oversampling with a 3-sample
// majority vote per bit.
//   clk         : system clock (CLK_FREQ Hz)
//   reset_n     : asynchronous active-low reset
//   baud_set    : rate select, latched at each start bit
//   uart_rx     : serial line, asynchronous, idle high
//   data_byte   : last correctly framed byte
//   rx_done     : one-cycle pulse, data_byte valid in the same cycle
//   frame_error : one-cycle pulse when the stop bit is read as 0
//   uart_state  : high while a frame is being received
// -----------------------------------------------------------------------------
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] baud_set,
    input  logic       uart_rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_error,
    output logic       uart_state
);

    logic rx_sync;
    logic start_det;

    uart_rx_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_async  (uart_rx),
        .rx_sync   (rx_sync),
        .start_det (start_det)
    );

    rx_state_e        state_q,       state_d;
    logic [2:0]       baud_q,        baud_d;
    logic [DIV_W-1:0] div_cnt_q,     div_cnt_d;
    logic [7:0]       tick_cnt_q,    tick_cnt_d;
    logic [1:0]       samp_q,        samp_d;
    logic [7:0]       shift_q,       shift_d;
    logic [7:0]       data_byte_q,   data_byte_d;
    logic             rx_done_q,     rx_done_d;
    logic             frame_error_q, frame_error_d;
    logic             uart_state_q,  uart_state_d;

    logic [DIV_W-1:0] div_term;
    logic             tick;
    logic [3:0]       slot;
    logic [3:0]       phase;
    logic             vote;

    // The divider follows the rate latched at start, not the live input.
    assign div_term = baud_div_term(baud_q, CLK_FREQ);
    assign tick     = (state_q == ST_RECV) && (div_cnt_q == div_term);

    // tick_cnt = 16*slot + phase; slot 0 = start, 1..8 = d0..d7, 9 = stop.
    assign slot  = tick_cnt_q[7:4];
    assign phase = tick_cnt_q[3:0];

    always_comb begin
        // NOTE: every always_comb target gets a default before any branch so
        // that paths which do not assign it cannot infer a latch.
        state_d       = state_q;
        baud_d        = baud_q;
        div_cnt_d     = div_cnt_q;
        tick_cnt_d    = tick_cnt_q;
        samp_d        = samp_q;
        shift_d       = shift_q;
        data_byte_d   = data_byte_q;
        rx_done_d     = 1'b0;
        frame_error_d = 1'b0;
        uart_state_d  = uart_state_q;
        vote          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d  = '0;
                tick_cnt_d = '0;
                if (start_det) begin
                    state_d      = ST_RECV;
                    baud_d       = baud_set;
                    uart_state_d = 1'b1;
                end
            end

            ST_RECV: begin
                if (!tick) begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end else begin
                    div_cnt_d  = '0;
                    tick_cnt_d = tick_cnt_q + 8'd1;
                    case (phase)
                        4'd6: samp_d[0] = rx_sync;
                        4'd7: samp_d[1] = rx_sync;
                        4'd8: begin
                            vote = majority3(samp_q[0], samp_q[1], rx_sync);
                            if (slot == 4'd0) begin
                                // A start bit that is not low at mid-bit was a glitch.
                                if (vote) begin
                                    state_d      = ST_IDLE;
                                    uart_state_d = 1'b0;
                                end
                            end else if (tick_cnt_q == TICK_LAST) begin
                                // Finishing at mid-stop-bit leaves half a bit to
                                // re-arm, so a back-to-back start bit is caught.
                                state_d      = ST_DONE;
                                uart_state_d = 1'b0;
                                if (vote) begin
                                    data_byte_d = shift_q;
                                    rx_done_d   = 1'b1;
                                end else begin
                                    frame_error_d = 1'b1;
                                end
                            end else begin
                                // LSB arrives first, so it ends up in bit 0.
                                shift_d = {vote, shift_q[7:1]};
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_DONE: begin
                // The pulse outputs are visible during this cycle.
                state_d    = ST_IDLE;
                div_cnt_d  = '0;
                tick_cnt_d = '0;
            end

            default: begin
                state_d      = ST_IDLE;
                uart_state_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            baud_q        <= '0;
            div_cnt_q     <= '0;
            tick_cnt_q    <= '0;
            samp_q        <= '0;
            shift_q       <= '0;
            data_byte_q   <= '0;
            rx_done_q     <= 1'b0;
            frame_error_q <= 1'b0;
            uart_state_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            div_cnt_q     <= div_cnt_d;
            tick_cnt_q    <= tick_cnt_d;
            samp_q        <= samp_d;
            shift_q       <= shift_d;
            data_byte_q   <= data_byte_d;
            rx_done_q     <= rx_done_d;
            frame_error_q <= frame_error_d;
            uart_state_q  <= uart_state_d;
        end
    end

    assign data_byte   = data_byte_q;
    assign rx_done     = rx_done_q;
    assign frame_error = frame_error_q;
    assign uart_state  = uart_state_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_byte_rx
// Directed frames are driven on uart_rx; each frame's expected outcome is
// queued when it is issued, and a monitor pops and compares on every
// rx_done / frame_error pulse.
// -----------------------------------------------------------------------------
module tb_uart_byte_rx;

    localparam int CPB_115200 = 434;
    localparam int CPB_57600  = 868;
    localparam int CPB_38400  = 1302;

    typedef struct {
        logic       is_err;
        logic [7:0] data;    // expected data_byte at the pulse
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] baud_set;
    logic       uart_rx;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_error;
    logic       uart_state;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   last_pulse_cyc = 0;
    logic prev_pulse = 1'b0;

    uart_byte_rx #(.CLK_FREQ(50_000_000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .baud_set    (baud_set),
        .uart_rx     (uart_rx),
        .data_byte   (data_byte),
        .rx_done     (rx_done),
        .frame_error (frame_error),
        .uart_state  (uart_state)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (rx_done || frame_error)) begin
            check("pulse_exclusive", {31'd0, rx_done & frame_error}, 32'd0);
            check("pulse_one_cycle", {31'd0, prev_pulse}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got rx_done=%0b frame_error=%0b data_byte=0x%02h, required no pulse",
                         rx_done, frame_error, data_byte);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_frame_error", {31'd0, frame_error}, {31'd0, e.is_err});
                check("data_byte", {24'd0, data_byte}, {24'd0, e.data});
                last_pulse_cyc = cyc;
            end
        end
        prev_pulse <= rx_done | frame_error;
    end

    // Drives slots 0..nslots-1 of a frame (start, d0..d7, stop); caller is at a negedge.
    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_val,
                              input int nslots);
        logic [9:0] bits;
        bits = {stop_val, b, 1'b0};
        start_cyc = cyc;
        for (int s = 0; s < nslots; s++) begin
            uart_rx = bits[s];
            repeat (cpb) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = b;
        exp_q.push_back(e);
    endtask

    task automatic wait_empty(input string name, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d pulses still pending after %0d cycles, required 0",
                     name, exp_q.size(), bound);
            exp_q.delete();
        end
    endtask

    // Short low glitch: the start vote fails after 9 ticks of DIV clocks,
    // plus a few cycles of synchronizer/FSM latency.
    task automatic glitch(input string name, input int lo, input int hi);
        int t0;
        int n;
        uart_rx = 1'b0;
        t0 = cyc;
        repeat (100) @(negedge clk);
        uart_rx = 1'b1;
        check({name, "_busy"}, {31'd0, uart_state}, 32'd1);
        n = 0;
        while (uart_state && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check_range({name, "_idle_after"}, cyc - t0, lo, hi);
        repeat (300) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        reset_n  = 1'b0;
        uart_rx  = 1'b1;
        baud_set = 3'd4;
        repeat (500) @(negedge clk);
        check("reset_data_byte",   {24'd0, data_byte}, 32'd0);
        check("reset_rx_done",     {31'd0, rx_done}, 32'd0);
        check("reset_frame_error", {31'd0, frame_error}, 32'd0);
        check("reset_uart_state",  {31'd0, uart_state}, 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        // 0xAA at 115200, with mid-frame busy and rx_done latency checks.
        push_byte(8'hAA);
        fork
            send_frame(8'hAA, CPB_115200, 1'b1, 10);
            begin
                repeat (5 * CPB_115200) @(negedge clk);
                check("aa_uart_state_mid", {31'd0, uart_state}, 32'd1);
            end
        join
        wait_empty("aa", 500);
        check_range("aa_latency", last_pulse_cyc - start_cyc, 4128, 4140);
        repeat (300) @(negedge clk);
        check("aa_uart_state_after", {31'd0, uart_state}, 32'd0);

        // 100-cycle glitch at 115200: 9 ticks * 27 = 243, and no later than 250.
        glitch("glitch_115200", 243, 250);

        // Stop bit forced 0: frame_error only, data_byte keeps 0xAA.
        e.is_err = 1'b1;
        e.data   = 8'hAA;
        exp_q.push_back(e);
        send_frame(8'hF0, CPB_115200, 1'b0, 10);
        wait_empty("f0_stop0", 500);
        repeat (300) @(negedge clk);

        // Back-to-back with no idle gap.
        push_byte(8'h01);
        push_byte(8'h80);
        push_byte(8'hFF);
        send_frame(8'h01, CPB_115200, 1'b1, 10);
        send_frame(8'h80, CPB_115200, 1'b1, 10);
        send_frame(8'hFF, CPB_115200, 1'b1, 10);
        wait_empty("b2b", 500);
        repeat (300) @(negedge clk);

        // Reset in the middle of a frame: nothing reported for it.
        send_frame(8'h77, CPB_115200, 1'b1, 5);
        check("abort_busy_before", {31'd0, uart_state}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_data_byte",   {24'd0, data_byte}, 32'd0);
        check("abort_uart_state",  {31'd0, uart_state}, 32'd0);
        check("abort_rx_done",     {31'd0, rx_done}, 32'd0);
        check("abort_frame_error", {31'd0, frame_error}, 32'd0);
        repeat (20) @(negedge clk);
        reset_n = 1'b1;
        repeat (1000) @(negedge clk);
        push_byte(8'h5A);
        send_frame(8'h5A, CPB_115200, 1'b1, 10);
        wait_empty("after_abort", 500);
        repeat (300) @(negedge clk);

        // 38400.
        baud_set = 3'd2;
        push_byte(8'h55);
        send_frame(8'h55, CPB_38400, 1'b1, 10);
        wait_empty("b38400", 1500);
        repeat (500) @(negedge clk);

        // 57600 with baud_set changed to 9600 mid-frame: frame still decodes.
        baud_set = 3'd3;
        push_byte(8'h3C);
        fork
            send_frame(8'h3C, CPB_57600, 1'b1, 10);
            begin
                repeat (4 * CPB_57600) @(negedge clk);
                baud_set = 3'd0;
            end
        join
        wait_empty("b57600_change", 1000);
        repeat (500) @(negedge clk);

        // Divider at 9600 (DIV 325) and 19200 (DIV 162), via glitch rejection time.
        baud_set = 3'd0;
        glitch("glitch_9600", 9 * 325, 9 * 325 + 10);
        baud_set = 3'd1;
        glitch("glitch_19200", 9 * 162, 9 * 162 + 10);

        // Further bytes at 115200.
        baud_set = 3'd4;
        push_byte(8'hC3);
        push_byte(8'h00);
        send_frame(8'hC3, CPB_115200, 1'b1, 10);
        send_frame(8'h00, CPB_115200, 1'b1, 10);
        wait_empty("tail", 500);
        repeat (100) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
